// File: rtl/alusrc_sel_pipe.sv
// Registered ALU operand-B source select followed by a DEPTH-entry valid/ready FIFO.
// Optional ALUSRC_SEXT_EN: EXT mode sign-extends to_ext instead of zero-extending.
module alusrc_sel_pipe #(
    parameter int DATA_W = 8,
    parameter int IMM_W  = 4,
    parameter int INC_W  = 3,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 alu_src,
    input  logic [DATA_W-1:0]          read0,
    input  logic [DATA_W-1:0]          read1,
    input  logic [IMM_W-1:0]           to_ext,
    input  logic [INC_W-1:0]           to_inc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          sel_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] SRC_INC  = 2'b00;
    localparam logic [1:0] SRC_EXT  = 2'b01;
    localparam logic [1:0] SRC_REG0 = 2'b10;
    localparam logic [1:0] SRC_REG1 = 2'b11;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] ext_val;
    logic [DATA_W-1:0] sel_val;
    logic              push;
    logic              pop;

`ifdef ALUSRC_SEXT_EN
    assign ext_val = DATA_W'($signed(to_ext));
`else
    assign ext_val = DATA_W'(to_ext);
`endif

    always_comb begin
        sel_val = '0;
        case (alu_src)
            SRC_INC:  sel_val = DATA_W'(to_inc) + DATA_W'(1);
            SRC_EXT:  sel_val = ext_val;
            SRC_REG0: sel_val = read0;
            SRC_REG1: sel_val = read1;
            default:  sel_val = '0;
        endcase
    end

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // When empty, present the most recently popped operand (0 after reset).
    assign sel_o   = out_valid ? mem_q[rd_ptr_q] : last_q;
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            last_d   = mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    // Storage needs no reset: it is only visible through sel_o while count_q != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sel_val;
        end
    end

endmodule
